// File: rtl/saradc_pkg.sv
// Shared types and constants for the SAR ADC controller.
// Define SARADC_CMP_SYNC_EN to pass CMP through a two-flop synchronizer.
package saradc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SMP    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_COMP   = 3'd3,
        ST_DONE   = 3'd4
    } saradc_state_e;

    localparam int SARADC_NBITS_DEF         = 8;
    localparam int SARADC_SAMPLE_CYCLES_DEF = 2;

`ifdef SARADC_CMP_SYNC_EN
    localparam int SARADC_COMP_LEN = 3;
`else
    localparam int SARADC_COMP_LEN = 1;
`endif

endpackage

// File: rtl/saradc_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator decision.
// Used only when SARADC_CMP_SYNC_EN is defined.
module saradc_cmp_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronization, both stages reset to 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/saradc_sar_ctrl.sv
// Successive-approximation controller: sample, settle, compare, MSB->LSB.
// Macro SARADC_CMP_SYNC_EN: synchronize CMP and stretch COMP to 3 cycles.
module saradc_sar_ctrl
    import saradc_pkg::*;
#(
    parameter int NBITS         = SARADC_NBITS_DEF,
    parameter int SAMPLE_CYCLES = SARADC_SAMPLE_CYCLES_DEF
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             CMP,
    output logic             SAMPLE,
    output logic             CMP_EN,
    output logic [NBITS-1:0] DAC,
    output logic [NBITS-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             BUSY
);

    localparam int IW = $clog2(NBITS);
    localparam int CW = $clog2(SAMPLE_CYCLES + SARADC_COMP_LEN + 1);

    localparam logic [CW-1:0] SMP_LAST  = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] COMP_LAST = CW'(SARADC_COMP_LEN - 1);
    localparam logic [IW-1:0] IDX_MSB   = IW'(NBITS - 1);

    saradc_state_e    r_state;
    saradc_state_e    w_next;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [NBITS-1:0] r_result;
    logic [NBITS-1:0] r_dout;
    logic             r_start;
    logic             r_sample;
    logic             r_cmp_en;
    logic             r_dvalid;
    logic             r_busy;
    logic             w_cmp;
    logic             w_comp_end;
    logic [NBITS-1:0] w_res_new;
    logic [NBITS-1:0] w_dac;

`ifdef SARADC_CMP_SYNC_EN
    saradc_cmp_sync u_cmp_sync (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_d     (CMP),
        .o_q     (w_cmp)
    );
`else
    assign w_cmp = CMP;
`endif

    assign w_comp_end = (r_state == ST_COMP) && (r_cnt == COMP_LAST);

    // Result with the bit under test replaced by the comparator decision
    always_comb begin
        w_res_new        = r_result;
        w_res_new[r_idx] = w_cmp;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_start) w_next = ST_SMP;
            end
            ST_SMP: begin
                if (r_cnt == SMP_LAST) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_next = ST_COMP;
            end
            ST_COMP: begin
                if (w_comp_end) begin
                    w_next = (r_idx == '0) ? ST_DONE : ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (DREADY) w_next = START ? ST_SMP : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, step counter, request latch and registered outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_start  <= 1'b0;
            r_sample <= 1'b0;
            r_cmp_en <= 1'b0;
            r_dvalid <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_start  <= (r_state == ST_IDLE) && START && !r_start;
            r_sample <= (w_next == ST_SMP);
            r_cmp_en <= (r_state == ST_SETTLE);
            r_dvalid <= (w_next == ST_DONE);
            r_busy   <= (w_next != ST_IDLE);
            if ((w_next == r_state) &&
                ((r_state == ST_SMP) || (r_state == ST_COMP))) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Bit index, partial result and final code
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_idx    <= '0;
            r_result <= '0;
            r_dout   <= '0;
        end else begin
            if ((r_state == ST_SMP) && (w_next == ST_SETTLE)) begin
                r_result <= '0;
                r_idx    <= IDX_MSB;
            end else if (w_comp_end) begin
                r_result <= w_res_new;
                if (r_idx == '0) begin
                    r_dout <= w_res_new;
                end else begin
                    r_idx <= r_idx - 1'b1;
                end
            end
        end
    end

    // DAC code decoded from registered state only
    always_comb begin
        w_dac = '0;
        unique case (r_state)
            ST_SETTLE, ST_COMP: w_dac = r_result | (NBITS'(1) << r_idx);
            ST_DONE:            w_dac = r_dout;
            default:            w_dac = '0;
        endcase
    end

    assign SAMPLE = r_sample;
    assign CMP_EN = r_cmp_en;
    assign DAC    = w_dac;
    assign DOUT   = r_dout;
    assign DVALID = r_dvalid;
    assign BUSY   = r_busy;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Self-checking bench for saradc_sar_ctrl with a behavioural comparator.
// Honours SARADC_CMP_SYNC_EN for expected latency and period.
module tb_saradc_sar_ctrl;

    localparam int NBITS = 8;
    localparam int SC    = 2;
`ifdef SARADC_CMP_SYNC_EN
    localparam int STEP  = 4;
`else
    localparam int STEP  = 2;
`endif
    localparam int LAT   = 1 + SC + STEP * NBITS;
    localparam int PER   = SC + STEP * NBITS + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             cmp;
    logic             sample;
    logic             cmp_en;
    logic [NBITS-1:0] dac;
    logic [NBITS-1:0] dout;
    logic             dvalid;
    logic             dready;
    logic             busy;

    // 0: Vin >= DAC, 1: constant 1, 2: constant 0
    int               mode;
    logic [NBITS-1:0] vin;

    int n_tests;
    int n_fail;

    assign cmp = (mode == 0) ? (vin >= dac) : (mode == 1);

    saradc_sar_ctrl #(
        .NBITS         (NBITS),
        .SAMPLE_CYCLES (SC)
    ) dut (
        .CLK    (clk),
        .RSTN   (rst_n),
        .START  (start),
        .CMP    (cmp),
        .SAMPLE (sample),
        .CMP_EN (cmp_en),
        .DAC    (dac),
        .DOUT   (dout),
        .DVALID (dvalid),
        .DREADY (dready),
        .BUSY   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Binary search as the comparator model would answer it
    function automatic logic ref_cmp(input int m, input logic [NBITS-1:0] v,
                                     input logic [NBITS-1:0] t);
        if (m == 0) return v >= t;
        return m == 1;
    endfunction

    task automatic convert(input string tag, input int m,
                           input logic [NBITS-1:0] v, input int stall);
        logic [NBITS-1:0] exp_code;
        logic [NBITS-1:0] exp_tr[$];
        logic [NBITS-1:0] got_tr[$];
        logic [NBITS-1:0] t;
        int               cyc;
        bit               stable;
        exp_code = '0;
        for (int k = NBITS - 1; k >= 0; k--) begin
            t = exp_code | (NBITS'(1) << k);
            exp_tr.push_back(t);
            if (ref_cmp(m, v, t)) exp_code = t;
        end
        mode   = m;
        vin    = v;
        dready = (stall == 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (cmp_en) got_tr.push_back(dac);
            if (dvalid) break;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, LAT);
        chk({tag, "_dout"}, dout, exp_code);
        chk({tag, "_dac_done"}, dac, exp_code);
        chk({tag, "_ntrials"}, got_tr.size(), NBITS);
        for (int i = 0; i < got_tr.size() && i < NBITS; i++) begin
            chk($sformatf("%s_trial%0d", tag, i), got_tr[i], exp_tr[i]);
        end
        if (stall > 0) begin
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                if (i == 2) start = 1'b1;
                if (i == 3) start = 1'b0;
                @(negedge clk);
                if (!dvalid || dout !== exp_code || !busy) stable = 1'b0;
            end
            start = 1'b0;
            chk({tag, "_stall_stable"}, stable, 1);
        end
        dready = 1'b1;
        @(negedge clk);
        chk({tag, "_idle"}, {dvalid, busy}, 0);
        if (stall > 0) begin
            repeat (3) @(negedge clk);
            chk({tag, "_no_restart"}, {busy, sample}, 0);
        end
    endtask

    initial begin
        int               cyc;
        int               pulses;
        logic [NBITS-1:0] v;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        dready  = 1'b1;
        mode    = 0;
        vin     = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {sample, cmp_en, dac, dout, dvalid, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        convert("basic_a5", 0, 8'hA5, 0);
        convert("all_ones", 1, 8'h00, 0);
        convert("all_zero", 2, 8'hFF, 0);
        convert("backpressure", 0, 8'h5A, 10);

        // Back-to-back with START and DREADY held high
        mode   = 0;
        vin    = 8'h3C;
        dready = 1'b1;
        start  = 1'b1;
        for (int i = 0; i < 200 && !dvalid; i++) @(negedge clk);
        chk("b2b_first", dout, 8'h3C);
        vin = 8'hC3;
        @(negedge clk);
        cyc = 1;
        for (int i = 0; i < 200 && !dvalid; i++) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_period", cyc, PER);
        chk("b2b_second", dout, 8'hC3);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_idle", busy, 0);

        // Reset during the COMP cycle of bit 4
        vin   = 8'h96;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200 && pulses < 4; i++) begin
            @(negedge clk);
            if (cmp_en) pulses++;
        end
        chk("rst_reached_bit4", dac, 8'h90);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {sample, cmp_en, dac, dout, dvalid, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert("after_reset", 0, 8'h96, 0);

        for (int n = 0; n < 6; n++) begin
            v = NBITS'($urandom_range(0, 255));
            convert($sformatf("rand%0d", n), 0, v, int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
